// File: rtl/pri_pkg.sv
// pri_pkg: shared state encoding for the priority scanner.
package pri_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
endpackage

// File: rtl/pri_onehot.sv
// pri_onehot: isolates the lowest (or highest when MSB_FIRST) set bit of i_req.
module pri_onehot #(
    parameter int W = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_gnt
);
    logic [W-1:0] w_req, w_gnt;
    for (genvar k = 0; k < W; k++) begin : g_rev
        assign w_req[k] = MSB_FIRST ? i_req[W-1-k] : i_req[k];
        assign o_gnt[k] = MSB_FIRST ? w_gnt[W-1-k] : w_gnt[k];
    end
    // two's-complement trick keeps only the lowest set bit
    assign w_gnt = w_req & (~w_req + W'(1));
endmodule

// File: rtl/pri_scan.sv
// pri_scan: loads a vector and emits its set bits one per handshake,
// selected by a two-level (group, then in-group) priority tree.
module pri_scan
    import pri_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         init_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             onehot_o,
    output logic [$clog2(WIDTH)-1:0]     index_o,
    output logic                         last_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(WIDTH+1)-1:0]   count_o
);
    localparam int NG = WIDTH / GROUP;
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    state_t r_state, w_next;
    logic [WIDTH-1:0] mask_r, w_src, w_sel;
    logic [NG-1:0] w_gor, w_gsel;
    logic [IW-1:0] w_idx;
    logic w_hs, w_adv;

    // a reload always wins, so one selector serves both data_i and mask_r
    assign w_src = init_i ? data_i : mask_r;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign w_gor[g] = |w_src[g*GROUP +: GROUP];
        pri_onehot #(.W(GROUP), .MSB_FIRST(MSB_FIRST)) u_in (
            .i_req(w_src[g*GROUP +: GROUP] & {GROUP{w_gsel[g]}}),
            .o_gnt(w_sel[g*GROUP +: GROUP])
        );
    end

    pri_onehot #(.W(NG), .MSB_FIRST(MSB_FIRST)) u_grp (
        .i_req(w_gor),
        .o_gnt(w_gsel)
    );

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < WIDTH; k++)
            if (w_sel[k]) w_idx = w_idx | IW'(k);
    end

    assign w_hs   = valid_o & ready_i;
    assign last_o = valid_o & (mask_r == '0);
    assign w_adv  = (r_state == SCAN) & w_hs & ~init_i;
    assign busy_o = (r_state != IDLE);
    assign done_o = (r_state == FIN);

    always_comb begin
        w_next = r_state;
        w_next = init_i ? SCAN
               : (r_state == SCAN && ((w_hs && last_o) || !valid_o)) ? FIN
               : (r_state == FIN) ? IDLE
               : r_state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            mask_r   <= '0;
            onehot_o <= '0;
            index_o  <= '0;
            valid_o  <= 1'b0;
            count_o  <= '0;
        end else begin
            r_state <= w_next;
            if (init_i || w_adv) begin
                onehot_o <= w_sel;
                index_o  <= w_idx;
                mask_r   <= w_src & ~w_sel;
                valid_o  <= |w_src;
            end
            if (init_i) count_o <= '0;
            else if (w_adv) count_o <= count_o + CW'(1);
        end
    end
endmodule

// File: tb/tb_pri_scan.sv
// tb_pri_scan: table-driven scans with a queue scoreboard for LSB- and MSB-first instances.
module tb_pri_scan;
    logic clk_i = 1'b0, rst_i, init_i, ready_i;
    logic [63:0] data_i;
    logic valid_o, last_o, busy_o, done_o, m_valid, m_last, m_busy, m_done;
    logic [63:0] onehot_o, m_onehot;
    logic [5:0] index_o, m_index;
    logic [6:0] count_o, m_count;
    int checks = 0, errors = 0;
    int q[$], qm[$];

    typedef struct {
        logic [63:0] data;
        int stall;
        int first_l;
        int first_m;
        int cnt;
    } vec_t;
    vec_t tbl[8];

    always #5 clk_i = ~clk_i;

    pri_scan dut (
        .clk_i(clk_i), .rst_i(rst_i), .init_i(init_i), .data_i(data_i), .ready_i(ready_i),
        .valid_o(valid_o), .onehot_o(onehot_o), .index_o(index_o), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
    );

    pri_scan #(.MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk_i), .rst_i(rst_i), .init_i(init_i), .data_i(data_i), .ready_i(ready_i),
        .valid_o(m_valid), .onehot_o(m_onehot), .index_o(m_index), .last_o(m_last),
        .busy_o(m_busy), .done_o(m_done), .count_o(m_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, valid_o, 0);
        chk({nm, "_onehot"}, onehot_o, 0);
        chk({nm, "_index"}, index_o, 0);
        chk({nm, "_last"}, last_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_done"}, done_o, 0);
        chk({nm, "_count"}, count_o, 0);
    endtask

    task automatic run_scan(input logic [63:0] d, input int stall, input int first_l,
                            input int first_m, input int cnt);
        int n = 0, guard = 0, st = stall;
        bit first = 1'b1;
        logic [63:0] oh;
        q.delete();
        qm.delete();
        for (int k = 0; k < 64; k++) if (d[k]) q.push_back(k);
        for (int k = 63; k >= 0; k--) if (d[k]) qm.push_back(k);
        init_i = 1'b1; data_i = d; ready_i = 1'b1;
        @(negedge clk_i);
        init_i = 1'b0; data_i = '0;
        if (d == 64'd0) begin
            chk("zero_valid", valid_o, 0);
            chk("zero_busy", busy_o, 1);
            chk("zero_done_early", done_o, 0);
            @(negedge clk_i);
        end
        while (q.size() > 0 && guard < 200) begin
            if (first) begin
                chk("first_lsb", index_o, first_l);
                chk("first_msb", m_index, first_m);
                first = 1'b0;
            end
            chk("valid", valid_o, 1);
            chk("index", index_o, q[0]);
            oh = 64'd1 << q[0];
            chk("onehot", onehot_o, oh);
            chk("last", last_o, q.size() == 1);
            chk("count_run", count_o, n);
            chk("done_mid", done_o, 0);
            chk("m_index", m_index, qm[0]);
            chk("m_last", m_last, qm.size() == 1);
            if (st > 0) begin
                ready_i = 1'b0;
                st--;
            end else begin
                ready_i = 1'b1;
                void'(q.pop_front());
                void'(qm.pop_front());
                n++;
            end
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 200) begin
            errors++;
            $display("FAIL scan_timeout act=%0d exp=0 remaining", q.size());
        end
        chk("done", done_o, 1);
        chk("done_busy", busy_o, 1);
        chk("done_valid", valid_o, 0);
        chk("done_index", index_o, 0);
        chk("count", count_o, cnt);
        chk("m_done", m_done, 1);
        chk("m_count", m_count, cnt);
        @(negedge clk_i);
        chk("done_pulse", done_o, 0);
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{64'h8000_0000_0000_0011, 0, 0, 63, 3};
        tbl[1] = '{64'h0, 0, 0, 0, 0};
        tbl[2] = '{64'h0000_0100_0000_0001, 3, 0, 40, 2};
        tbl[3] = '{64'h1, 0, 0, 0, 1};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 63, 64};
        tbl[5] = '{64'h8000_0000_0000_0000, 1, 63, 63, 1};
        tbl[6] = '{64'h00F0_0000_0000_0F00, 2, 8, 55, 8};
        tbl[7] = '{64'h5555_5555_5555_5555, 0, 0, 62, 32};

        rst_i = 1'b1; init_i = 1'b0; data_i = '0; ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        foreach (tbl[i]) run_scan(tbl[i].data, tbl[i].stall, tbl[i].first_l, tbl[i].first_m, tbl[i].cnt);

        // abort: reload after the first handshake of an 8'hF0 scan
        init_i = 1'b1; data_i = 64'hF0; ready_i = 1'b1;
        @(negedge clk_i);
        init_i = 1'b0;
        chk("abort_idx4", index_o, 4);
        @(negedge clk_i);
        chk("abort_idx5", index_o, 5);
        chk("abort_cnt1", count_o, 1);
        init_i = 1'b1; data_i = 64'h3;
        @(negedge clk_i);
        init_i = 1'b0;
        chk("abort_idx0", index_o, 0);
        chk("abort_cnt0", count_o, 0);
        chk("abort_nodone0", done_o, 0);
        @(negedge clk_i);
        chk("abort_idx1", index_o, 1);
        chk("abort_last", last_o, 1);
        chk("abort_nodone1", done_o, 0);
        @(negedge clk_i);
        chk("abort_done", done_o, 1);
        chk("abort_cnt2", count_o, 2);
        @(negedge clk_i);
        chk("abort_done_once", done_o, 0);

        // reset in the middle of a scan
        init_i = 1'b1; data_i = 64'hFF;
        @(negedge clk_i);
        init_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_idx", index_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_zero("midrst");
        rst_i = 1'b0;
        @(negedge clk_i);
        run_scan(64'h11, 1, 0, 4, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
